// File: rtl/mux3_rr_arbiter_pkg.sv
// Shared definitions for the three-way round-robin arbiter: state encoding,
// idle select code and one-hot <-> index helpers.
package mux3_rr_arbiter_pkg;

  // Select code driven while no requester owns the datapath.
  localparam logic [1:0] SEL_IDLE = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Requester index -> one-hot grant vector (unknown index gives no grant).
  function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // One-hot grant vector -> requester index (no owner gives SEL_IDLE).
  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    case (oh)
      3'b001:  idx = 2'd0;
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = SEL_IDLE;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/mux3_rr_arbiter_mux.sv
// Plain 3-to-1 data multiplexer; any select code other than 0..2 yields zero.
module mux_3to1_32bit #(
  parameter int WIDTH = 32
) (
  output logic [WIDTH-1:0] outp,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic [WIDTH-1:0] inp3,
  input  logic [1:0]       sel
);

  // Select one of the three inputs.
  always_comb begin
    outp = '0;
    case (sel)
      2'd0:    outp = inp1;
      2'd1:    outp = inp2;
      2'd2:    outp = inp3;
      default: outp = '0;
    endcase
  end

endmodule

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter sharing one datapath between three requesters.
// A grant lasts up to MAX_BEATS accepted beats; each release is followed by
// one idle bubble cycle where the next owner is chosen.
module mux3_rr_arbiter
  import mux3_rr_arbiter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_BEATS = 4,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [2:0]       grant,
  output logic [2:0]       ack,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  arb_state_e       state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic             owner_req;
  logic             accept;
  logic             last_beat;
  logic [1:0]       owner_idx;
  logic [1:0]       release_ptr;
  logic [WIDTH-1:0] mux_out;

  // First requester at or after ptr in circular order 0->1->2->0.
  // A pointer of 3 cannot occur in normal operation and is read as 0.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] ptr);
    logic [1:0] start;
    logic [2:0] rot;
    logic [1:0] off;
    logic [2:0] sum;
    start = (ptr == 2'b11) ? 2'd0 : ptr;
    // rot[k] is the request of the k-th candidate in search order
    case (start)
      2'd1:    rot = {r[0], r[2], r[1]};
      2'd2:    rot = {r[1], r[0], r[2]};
      default: rot = r;
    endcase
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else             off = 2'd2;
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= 3'd3) sum = sum - 3'd3;
    return sum[1:0];
  endfunction

  assign owner_idx   = onehot_to_idx(grant_q);
  assign release_ptr = (owner_idx == 2'd2) ? 2'd0 : owner_idx + 2'd1;
  assign owner_req   = |(grant_q & req);
  assign last_beat   = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));

  // Reset wins over a beat in flight: nothing is offered or acknowledged.
  assign out_valid = (state_q == ST_GRANT) && owner_req && !reset;
  assign accept    = out_valid && out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ack
      assign ack[gi] = grant_q[gi] & accept;
    end
  endgenerate

  mux_3to1_32bit #(
    .WIDTH (WIDTH)
  ) u_mux (
    .outp (mux_out),
    .inp1 (data0),
    .inp2 (data1),
    .inp3 (data2),
    .sel  (sel_q)
  );

  assign out_data = (state_q == ST_IDLE) ? '0 : mux_out;
  assign grant    = grant_q;
  assign sel      = sel_q;

  // Next-state: pick a winner from IDLE, count beats and release from GRANT.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d    = ST_GRANT;
          sel_d      = rr_pick(req, rr_ptr_q);
          grant_d    = idx_to_onehot(rr_pick(req, rr_ptr_q));
          beat_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (!owner_req || (accept && last_beat)) begin
          state_d    = ST_IDLE;
          grant_d    = 3'b000;
          sel_d      = SEL_IDLE;
          rr_ptr_d   = release_ptr;
          beat_cnt_d = '0;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        grant_d    = 3'b000;
        sel_d      = SEL_IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= 3'b000;
      sel_q      <= SEL_IDLE;
      rr_ptr_q   <= 2'd0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Bench for mux3_rr_arbiter: expected beats are queued as they are set up and
// checked against every ack seen on the falling edge.
module tb_mux3_rr_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req;
  logic [31:0] data0, data1, data2;
  logic [2:0]  grant;
  logic [2:0]  ack;
  logic [1:0]  sel;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]  ack;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];

  mux3_rr_arbiter #(
    .WIDTH     (32),
    .MAX_BEATS (4),
    .CNT_W     (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .grant     (grant),
    .ack       (ack),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] data_of(input int owner);
    case (owner)
      0:       return data0;
      1:       return data1;
      default: return data2;
    endcase
  endfunction

  task automatic push_beat(input int owner);
    beat_t b;
    b.ack  = 3'(1 << owner);
    b.data = data_of(owner);
    exp_q.push_back(b);
  endtask

  task automatic chk_idle(input string tag);
    chk_val({tag, "_grant"}, 32'(grant), 32'h0);
    chk_val({tag, "_sel"}, 32'(sel), 32'h3);
    chk_val({tag, "_valid"}, 32'(out_valid), 32'h0);
    chk_val({tag, "_data"}, out_data, 32'h0);
  endtask

  task automatic chk_owner(input string tag, input int owner);
    chk_val({tag, "_grant"}, 32'(grant), 32'(1 << owner));
    chk_val({tag, "_sel"}, 32'(sel), 32'(owner));
  endtask

  // Called in an idle cycle with req already set: one edge to grant, then
  // nbeats accepted beats, ending in the release bubble.
  task automatic run_grant(input string tag, input int owner, input int nbeats);
    tick();
    for (int b = 0; b < nbeats; b++) begin
      chk_owner(tag, owner);
      chk_val({tag, "_valid"}, 32'(out_valid), 32'h1);
      push_beat(owner);
      tick();
    end
    chk_idle({tag, "_bubble"});
  endtask

  // Scoreboard consumer: each ack must match the next queued beat.
  always @(negedge clk) begin
    if (ack != 3'b000) begin
      if (exp_q.size() == 0) begin
        chk_val("sb_unexpected_ack", 32'(ack), 32'h0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk_val("sb_ack", 32'(ack), 32'(e.ack));
        chk_val("sb_data", out_data, e.data);
        $display("[TB] beat ack=%b data=%h", ack, out_data);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    req       = 3'b111;
    out_ready = 1'b1;
    data0     = 32'h0000_0000;
    data1     = 32'hFFFF_FFFF;
    data2     = 32'h0000_FFFF;

    // Reset held for two cycles with all requests up
    tick(); chk_idle("rst1"); chk_val("rst1_ack", 32'(ack), 32'h0);
    tick(); chk_idle("rst2"); chk_val("rst2_ack", 32'(ack), 32'h0);
    reset = 1'b0;

    // Rotation 0 -> 1 -> 2 -> 0
    run_grant("rot0", 0, 4);
    run_grant("rot1", 1, 4);
    run_grant("rot2", 2, 4);
    run_grant("rot0b", 0, 4);

    // Owner 1 drops its request after two beats
    tick();
    for (int b = 0; b < 2; b++) begin
      chk_owner("drop", 1);
      push_beat(1);
      tick();
    end
    req = 3'b101;
    #1;
    chk_val("drop_valid", 32'(out_valid), 32'h0);
    chk_val("drop_ack", 32'(ack), 32'h0);
    tick();
    chk_idle("drop_rel");
    run_grant("drop_next2", 2, 4);

    // Stall for ten cycles in the middle of a grant
    data0 = 32'hA5A5_0F0F;
    data1 = 32'h1234_5678;
    data2 = 32'hDEAD_BEEF;
    req   = 3'b111;
    tick();
    chk_owner("stall_b1", 0);
    push_beat(0);
    tick();
    out_ready = 1'b0;
    #1;
    for (int c = 0; c < 10; c++) begin
      chk_val("stall_ack", 32'(ack), 32'h0);
      chk_owner("stall", 0);
      chk_val("stall_data", out_data, 32'hA5A5_0F0F);
      chk_val("stall_valid", 32'(out_valid), 32'h1);
      tick();
    end
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      chk_owner("stall_resume", 0);
      push_beat(0);
      tick();
    end
    chk_idle("stall_bubble");

    // Reset during the third beat of owner 1
    tick();
    for (int b = 0; b < 2; b++) begin
      chk_owner("rstmid", 1);
      push_beat(1);
      tick();
    end
    reset = 1'b1;
    #1;
    chk_val("rstmid_ack", 32'(ack), 32'h0);
    tick();
    reset = 1'b0;
    chk_idle("rstmid_after");
    run_grant("rstmid_ptr0", 0, 4);

    // Single requester 2
    req = 3'b100;
    run_grant("single_a", 2, 4);
    run_grant("single_b", 2, 4);
    run_grant("single_c", 2, 4);

    req = 3'b000;
    tick();
    chk_idle("final");
    chk_val("sb_left", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
